// File: rtl/ex_muldiv_stage.sv
// EX-stage multiply/divide unit with HI/LO registers.
// Iterative: 32 shift-add or restoring-divide steps, then a sign fix-up cycle.
module ex_muldiv_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  alu_op_in,
    input  logic [5:0]  funct_in,
    input  logic [31:0] operand_a_in,
    input  logic [31:0] operand_b_in,
    output logic        stall_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] result_out,
    output logic        busy_out
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_b;
    logic [31:0] r_raw_a;
    logic [63:0] r_acc;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;

    logic        w_rtype;
    logic        w_mult;
    logic        w_multu;
    logic        w_div;
    logic        w_divu;
    logic        w_mfhi;
    logic        w_mthi;
    logic        w_mflo;
    logic        w_mtlo;
    logic        w_signed;
    logic        w_start;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    assign w_rtype  = (alu_op_in == 2'b10);
    assign w_mult   = w_rtype && (funct_in == 6'h18);
    assign w_multu  = w_rtype && (funct_in == 6'h19);
    assign w_div    = w_rtype && (funct_in == 6'h1A);
    assign w_divu   = w_rtype && (funct_in == 6'h1B);
    assign w_mfhi   = w_rtype && (funct_in == 6'h10);
    assign w_mthi   = w_rtype && (funct_in == 6'h11);
    assign w_mflo   = w_rtype && (funct_in == 6'h12);
    assign w_mtlo   = w_rtype && (funct_in == 6'h13);
    assign w_signed = w_mult | w_div;

    assign w_start = (r_state == S_IDLE) && !flush
                   && (w_mult | w_multu | w_div | w_divu);

    assign w_a_mag = (w_signed && operand_a_in[31])
                   ? (~operand_a_in + 32'd1) : operand_a_in;
    assign w_b_mag = (w_signed && operand_b_in[31])
                   ? (~operand_b_in + 32'd1) : operand_b_in;

    // One iteration: acc low half holds multiplier / shifting dividend.
    logic [32:0] w_add;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_step;

    assign w_add    = {1'b0, r_acc[63:32]}
                    + {1'b0, (r_acc[0] ? r_b : 32'd0)};
    assign w_rem_sh = {r_acc[63:32], r_acc[31]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_sub    = w_rem_sh[31:0] - r_b;

    always_comb begin
        w_step = {w_add, r_acc[31:1]};
        if (r_is_div) begin
            if (w_ge) w_step = {w_sub, r_acc[30:0], 1'b1};
            else      w_step = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
        end
    end

    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    assign w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    assign w_quo  = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_fix_hi = w_prod[63:32];
        w_fix_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_b == 32'd0) begin
                w_fix_hi = r_raw_a;
                w_fix_lo = 32'hFFFF_FFFF;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next = S_CALC;
            S_CALC: begin
                if (flush)              w_next = S_IDLE;
                else if (r_cnt == 5'd31) w_next = S_FIX;
            end
            S_FIX:  w_next = flush ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 5'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_b       <= 32'd0;
            r_raw_a   <= 32'd0;
            r_acc     <= 64'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_acc     <= {32'd0, w_a_mag};
                        r_b       <= w_b_mag;
                        r_raw_a   <= operand_a_in;
                        r_is_div  <= w_div | w_divu;
                        r_neg_res <= w_signed
                                   && (operand_a_in[31] ^ operand_b_in[31]);
                        r_neg_rem <= w_div && operand_a_in[31];
                        r_cnt     <= 5'd0;
                    end else if (!flush) begin
                        if (w_mthi) r_hi <= operand_a_in;
                        if (w_mtlo) r_lo <= operand_a_in;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_out  = w_start || (r_state == S_CALC) || (r_state == S_FIX);
    assign busy_out   = (r_state == S_CALC) || (r_state == S_FIX);
    assign hi_out     = r_hi;
    assign lo_out     = r_lo;
    assign result_out = w_mfhi ? r_hi : (w_mflo ? r_lo : 32'd0);

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage: directed literal cases plus random
// pipeline-style traffic checked every cycle against a countdown model.
module tb_ex_muldiv_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] result_out;
    logic        busy_out;

    ex_muldiv_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_op_in(alu_op), .funct_in(funct),
        .operand_a_in(a), .operand_b_in(b),
        .stall_out(stall_out), .hi_out(hi_out), .lo_out(lo_out),
        .result_out(result_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [31:0] p_hi = 0;
    logic [31:0] p_lo = 0;
    int          m_cnt = 0;
    bit          m_done = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit is_muldiv(input logic [1:0] op,
                                     input logic [5:0] f);
        return op == 2'b10 && (f == 6'h18 || f == 6'h19 ||
                               f == 6'h1A || f == 6'h1B);
    endfunction

    // Returns {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input logic [5:0] f,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (f)
            6'h18: begin
                q = sx * sy;
                return q;
            end
            6'h19: return ux * uy;
            6'h1A: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hi = 0;
            m_lo = 0;
            m_cnt = 0;
            m_done = 0;
        end else if (m_cnt > 0) begin
            if (flush) m_cnt = 0;
            else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    m_done = 1;
                end
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (!flush) begin
            if (is_muldiv(alu_op, funct)) begin
                {p_hi, p_lo} = ref_op(funct, a, b);
                m_cnt = 33;
            end else if (alu_op == 2'b10) begin
                if (funct == 6'h11) m_hi = a;
                if (funct == 6'h13) m_lo = a;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_start;
            logic [31:0] e_res;
            e_start = m_cnt == 0 && !m_done && !flush
                    && is_muldiv(alu_op, funct);
            e_res = 0;
            if (alu_op == 2'b10 && funct == 6'h10) e_res = m_hi;
            if (alu_op == 2'b10 && funct == 6'h12) e_res = m_lo;
            check("cyc_stall", {31'd0, stall_out},
                  {31'd0, e_start || m_cnt > 0});
            check("cyc_busy", {31'd0, busy_out}, {31'd0, m_cnt > 0});
            check("cyc_hi", hi_out, m_hi);
            check("cyc_lo", lo_out, m_lo);
            check("cyc_result", result_out, e_res);
        end
    end

    task automatic drive(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #1;
        flush = 0;
        alu_op = op;
        funct = f;
        a = x;
        b = y;
    endtask

    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        n = 0;
        drive(2'b10, f, x, y);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_out) break;
            n++;
        end
        check({name, "_stall_len"}, n, 34);
        check({name, "_hi"}, hi_out, ehi);
        check({name, "_lo"}, lo_out, elo);
        check({name, "_model_hi"}, m_hi, ehi);
        check({name, "_model_lo"}, m_lo, elo);
        drive(2'b00, 6'h00, 0, 0);
        @(negedge clk);
        check({name, "_no_restart"}, {31'd0, busy_out}, 32'd0);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] ftab [10] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10,
                              6'h11, 6'h12, 6'h13, 6'h20, 6'h00};

    initial begin
        rst = 1;
        flush = 0;
        alu_op = 0;
        funct = 0;
        a = 0;
        b = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
        @(negedge clk);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_stall", {31'd0, stall_out}, 0);
        check("rst_result", result_out, 0);
        @(posedge clk);
        #1;
        rst = 0;

        run_op("mult_m3x7", 6'h18, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7d2", 6'h1A, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0", 6'h1B, 32'd100, 32'd0,
               32'd100, 32'hFFFF_FFFF);
        run_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000);

        drive(2'b10, 6'h11, 32'hAAAA, 0);
        drive(2'b10, 6'h13, 32'h5555, 0);
        drive(2'b10, 6'h18, 32'd3, 32'd5);
        repeat (11) @(posedge clk);
        #1;
        flush = 1;
        @(negedge clk);
        check("flush_pre_stall", {31'd0, stall_out}, 1);
        drive(2'b00, 6'h00, 0, 0);
        @(negedge clk);
        check("flush_stall", {31'd0, stall_out}, 0);
        check("flush_busy", {31'd0, busy_out}, 0);
        check("flush_hi", hi_out, 32'hAAAA);
        check("flush_lo", lo_out, 32'h5555);

        drive(2'b10, 6'h13, 32'h1234, 0);
        @(negedge clk);
        check("mtlo_stall", {31'd0, stall_out}, 0);
        drive(2'b10, 6'h12, 0, 0);
        @(negedge clk);
        check("mflo_result", result_out, 32'h1234);
        check("mflo_stall", {31'd0, stall_out}, 0);

        drive(2'b10, 6'h19, 32'd5, 32'd6);
        repeat (6) @(posedge clk);
        #1;
        rst = 1;
        alu_op = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("midrst_hi", hi_out, 0);
        check("midrst_lo", lo_out, 0);
        check("midrst_busy", {31'd0, busy_out}, 0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit s;
            @(negedge clk);
            s = stall_out;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 999) == 0);
            flush = ($urandom_range(0, 59) == 0);
            if (!s) begin
                alu_op = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b10;
                funct = ftab[$urandom_range(0, 9)];
                a = rnd32();
                b = rnd32();
            end else if ($urandom_range(0, 3) == 0) begin
                a = rnd32();
                b = rnd32();
            end
        end

        @(posedge clk);
        #1;
        rst = 0;
        flush = 0;
        alu_op = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_stage.md
EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: flush  input  1  synchronous abort of the in-flight operation.
REQ-005 Port: alu_op_in  input  2  ALU op from the ID/EX register; 2'b10 = R-type.
REQ-006 Port: funct_in  input  6  funct field from the ID/EX register.
REQ-007 Port: operand_a_in  input  32  rs value after forwarding.
REQ-008 Port: operand_b_in  input  32  rt value after forwarding.
REQ-009 Port: stall_out  output  1  hold PC, IF/ID and ID/EX while high.
REQ-010 Port: hi_out  output  32  current HI register.
REQ-011 Port: lo_out  output  32  current LO register.
REQ-012 Port: result_out  output  32  MFHI/MFLO result; 0 for any other funct.
REQ-013 Port: busy_out  output  1  high while in CALC or FIX.

Function
REQ-014 Op decode SHALL apply only when alu_op_in==2'b10, with these funct codes: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO.
REQ-015 States SHALL be IDLE, CALC, FIX and DONE, with a 5-bit iteration counter.
REQ-016 start SHALL be (state==IDLE) & ~flush & one of MULT/MULTU/DIV/DIVU decoded.
REQ-017 On start, the block SHALL:
- latch the operands (magnitudes for signed ops);
- latch the op and the sign flags;
- clear the counter;
- go to CALC.
REQ-018 CALC SHALL perform one iteration per cycle for 32 cycles:
- multiply uses shift-add on a 64-bit accumulator;
- divide uses restoring division.
REQ-019 After the counter reaches 31, the block SHALL go to FIX.
REQ-020 FIX SHALL apply sign correction and write HI/LO at the end of the cycle, then go to DONE:
- multiply: HI = product[63:32], LO = product[31:0];
- divide: LO = quotient, HI = remainder.
REQ-021 Signed sign rules SHALL be:
- MULT product is negated if the operand signs differ;
- DIV quotient is negated if the operand signs differ;
- DIV remainder takes the dividend's sign.
REQ-022 Divide by zero SHALL still take the full latency and SHALL produce LO=32'hFFFFFFFF, HI=operand_a (raw value).
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce LO=0x80000000, HI=0.
REQ-024 DONE SHALL last exactly one cycle:
- stall_out is low;
- start is suppressed, so the held instruction leaves ID/EX without restarting;
- the next state is IDLE.
REQ-025 stall_out SHALL be combinational: start | (state==CALC) | (state==FIX).
REQ-026 Total stall SHALL be 34 cycles (start cycle + 32 CALC + FIX); the new HI/LO SHALL be visible in DONE.
REQ-027 MTHI/MTLO SHALL write operand_a_in to HI/LO at the clock edge, only in IDLE and only with flush low.
REQ-028 MFHI/MFLO SHALL drive result_out combinationally from the current HI/LO with no stall.
REQ-029 flush SHALL behave as follows:
- in CALC or FIX, the block goes to IDLE with HI/LO unchanged, and stall_out is low from the next cycle;
- in DONE, the block goes to IDLE;
- in IDLE, flush suppresses start.
REQ-030 Priority SHALL be rst > flush > normal operation.
REQ-031 Input changes during CALC/FIX SHALL be ignored; only the latched operands are used.

Reset
REQ-032 rst at a clock edge SHALL force:
- state = IDLE, counter = 0;
- HI = LO = 0;
- all internal operand and accumulator registers = 0.
REQ-033 After reset, stall_out, busy_out and result_out SHALL be 0 unless a valid op is presented.
REQ-034 rst asserted mid-CALC SHALL abort the operation with HI=LO=0 on the following cycle.

Verification
REQ-035 MULT, a=0xFFFFFFFD (-3), b=7 -> stall 34 cycles; in DONE, HI=0xFFFFFFFF, LO=0xFFFFFFEB; stall low in DONE.
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
REQ-039 MULT started, flush at CALC cycle 10 -> next cycle state IDLE, stall 0, HI/LO hold their prior values.
REQ-040 MTLO 0x1234, then MFLO the next cycle -> result_out=0x1234 with no stall.
REQ-041 Instruction held in ID/EX through DONE -> no second start.
